legv8_pc_unit_ras: RTL and testbench
====================================

Name: legv8_pc_unit_ras

Overview:
Parametrised program-counter unit for the LEGv8 datapath, replacing the fixed 64-bit PC with its four select modes (hold, +4, load, relative).
- Adds a configurable step, a reset vector and an update enable.
- Adds a hardware return-address stack (RAS) for branch-with-link and return.
- Sits between the control-word decoder (PC_sel / PC_en fields) and the instruction-memory address bus.

Parameters:
PC_WIDTH, 64, PC and address width in bits
RESET_VECTOR, 0, PC value loaded on reset (PC_WIDTH bits)
STEP, 4, sequential increment in bytes
RAS_DEPTH, 4, return-address stack entries (>=2, power of two)

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  synchronous, active-high
pc_en  input  1  PC update enable; when 0, PC and RAS hold and link/ret are ignored
pc_sel  input  2  00 hold, 01 PC+STEP, 10 load in_addr, 11 PC+(offset<<2)
in_addr  input  PC_WIDTH  absolute target (register value)
offset  input  PC_WIDTH  signed word offset for relative branch
link  input  1  push return address (BL/BLR semantics)
ret  input  1  pop RAS into PC
pc  output  PC_WIDTH  current PC, registered
pc_plus_step  output  PC_WIDTH  combinational pc+STEP, mod 2^PC_WIDTH
ras_count  output  $clog2(RAS_DEPTH+1)  valid entries
ras_empty  output  1  ras_count==0
ras_full  output  1  ras_count==RAS_DEPTH
ras_overflow  output  1  sticky: push while full
ras_underflow  output  1  sticky: pop while empty

Behaviour:
- Reset (synchronous, clock edge with reset=1):
  - pc=RESET_VECTOR, ras_count=0.
  - ras_overflow=0, ras_underflow=0.
  - RAS contents are don't-care.
  - Reset overrides every other input, including a reset asserted mid-sequence.
- All updates occur on the rising clock edge and only when pc_en=1. One-cycle latency: the new pc is visible after the edge.
- Priority when pc_en=1: ret > pc_sel.
- ret=1, RAS non-empty:
  - pc <= top entry; ras_count decrements.
  - pc_sel and link are ignored that cycle.
- ret=1, RAS empty:
  - pc holds; ras_underflow sets (sticky until reset).
  - pc_sel and link are ignored.
- ret=0, pc_sel decides the next pc:
  - 00: pc holds.
  - 01: pc <= pc+STEP.
  - 10: pc <= in_addr.
  - 11: pc <= pc + (offset<<2).
- Width rules for pc_sel=11:
  - offset is two's complement; the shift discards the top 2 bits.
  - The sum is truncated to PC_WIDTH, so wrap-around is silent.
- link=1 with ret=0 and pc_sel in {10,11}: push pc+STEP (the pre-update pc) in the same edge as the pc load.
- link=1 with pc_sel in {00,01}: ignored, no push.
- Push while full:
  - RAS is circular; the oldest entry is overwritten.
  - ras_count stays RAS_DEPTH; ras_overflow sets (sticky).
  - The newest entry is always the top.
- Stack implementation: top pointer mod RAS_DEPTH plus a saturating count. A pop after an overflow returns entries newest-first, up to RAS_DEPTH of them.
- pc_en=0: nothing changes, and sticky flags do not set.
- pc_plus_step: purely combinational from pc.
- Flags ras_empty and ras_full: combinational from ras_count.

Optional Feature:
Macro PC_ALIGN_CHECK_EN.
- When defined:
  - Adds output pc_misaligned (1 bit, sticky, reset 0).
  - Any computed target (from pc_sel 10, 11, or a RAS pop) with bits [1:0] != 0 is rejected: pc holds, no push or pop occurs, and pc_misaligned sets.
- When undefined:
  - The port is absent.
  - Targets load unchecked, low bits included.

Test Plan:
1. Reset with RESET_VECTOR=0, then pc_en=1, pc_sel=01 for 3 cycles -> pc 0, 4, 8, 12; pc_plus_step=16; ras_empty=1.
2. From pc=12: pc_sel=10, in_addr=0x60000018, link=1 -> pc=0x60000018, ras_count=1, top=16. Next cycle ret=1 -> pc=16, ras_empty=1.
3. From pc=0x100: pc_sel=11, offset=-4 (all ones with low nibble C) -> pc=0xF0. With pc=0xFFFF_FFFF_FFFF_FFFC and pc_sel=01 -> pc wraps to 0.
4. Five linked calls (pc_sel=10, in_addr=0x1000·k for k=1..5), depth 4 -> ras_full=1, ras_overflow=1, ras_count=4. Four rets return the four newest return addresses, newest first. A fifth ret holds pc and sets ras_underflow.
5. pc_en=0 with pc_sel=01, link=1, ret=1 -> pc, ras_count and flags unchanged. ret=1 and pc_sel=10 together with pc_en=1 -> pop wins, in_addr ignored.
6. Mid-sequence reset with ras_count=2 and flags set -> next edge pc=RESET_VECTOR, count=0, flags=0. With PC_ALIGN_CHECK_EN, pc_sel=10, in_addr=0x6 -> pc holds, pc_misaligned=1.

Source files
------------

// File: rtl/legv8_pc_unit_ras.sv
// legv8_pc_unit_ras
//   Program-counter unit for the LEGv8 datapath. It supports four select
//   modes (hold, +STEP, absolute load, PC-relative), an update enable, a
//   reset vector, and a circular return-address stack (RAS) for
//   branch-with-link and return.
//
// Parameters
//   PC_WIDTH     PC / address width in bits
//   RESET_VECTOR PC value loaded on reset
//   STEP         sequential increment in bytes
//   RAS_DEPTH    return-address stack entries (>=2, power of two)
//
// Ports
//   clock          rising-edge system clock
//   reset          synchronous, active-high
//   pc_en          update enable; when low, PC, RAS and flags hold
//   pc_sel[1:0]    00 hold, 01 pc+STEP, 10 load in_addr, 11 pc+(offset<<2)
//   in_addr        absolute target
//   offset         signed word offset for relative branches
//   link           push pc+STEP together with a load/relative jump
//   ret            pop the RAS top into pc (takes priority over pc_sel)
//   pc             registered current PC
//   pc_plus_step   combinational pc+STEP
//   ras_count      number of valid RAS entries
//   ras_empty      ras_count == 0
//   ras_full       ras_count == RAS_DEPTH
//   ras_overflow   sticky: push while full
//   ras_underflow  sticky: pop while empty
//   pc_misaligned  sticky: rejected target with nonzero bits [1:0]
//                  (present only when PC_ALIGN_CHECK_EN is defined)
//
// Build option
//   PC_ALIGN_CHECK_EN  when defined, misaligned targets are rejected and
//                      reported on pc_misaligned; otherwise targets load
//                      unchecked.

module legv8_pc_unit_ras #(
  parameter int unsigned             PC_WIDTH     = 64,
  parameter logic [PC_WIDTH-1:0]     RESET_VECTOR = '0,
  parameter int unsigned             STEP         = 4,
  parameter int unsigned             RAS_DEPTH    = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               pc_en,
  input  logic [1:0]                         pc_sel,
  input  logic [PC_WIDTH-1:0]                in_addr,
  input  logic [PC_WIDTH-1:0]                offset,
  input  logic                               link,
  input  logic                               ret,
  output logic [PC_WIDTH-1:0]                pc,
  output logic [PC_WIDTH-1:0]                pc_plus_step,
  output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count,
  output logic                               ras_empty,
  output logic                               ras_full,
  output logic                               ras_overflow,
`ifdef PC_ALIGN_CHECK_EN
  output logic                               ras_underflow,
  output logic                               pc_misaligned
`else
  output logic                               ras_underflow
`endif
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  typedef enum logic [1:0] {
    SEL_HOLD = 2'b00,
    SEL_STEP = 2'b01,
    SEL_LOAD = 2'b10,
    SEL_REL  = 2'b11
  } sel_t;

  sel_t                  sel;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [PC_WIDTH-1:0]   pc_next;
  logic [PC_WIDTH-1:0]   rel_off;
  logic [PC_WIDTH-1:0]   target;
  logic                  take_target;

  logic [PC_WIDTH-1:0]   ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]      top;
  logic [PTR_W-1:0]      top_inc;
  logic [PTR_W-1:0]      top_dec;
  logic [CNT_W-1:0]      count_q;
  logic                  push;
  logic                  pop;
  logic                  ovf_q;
  logic                  unf_q;
  logic                  ovf_set;
  logic                  unf_set;
`ifdef PC_ALIGN_CHECK_EN
  logic                  mis_q;
  logic                  mis_set;
`endif

  // The shift by two discards offset's top two bits.
  logic unused_offset_hi;
  assign unused_offset_hi = ^offset[PC_WIDTH-1:PC_WIDTH-2];

  assign sel          = sel_t'(pc_sel);
  assign rel_off      = {offset[PC_WIDTH-3:0], 2'b00};
  assign pc           = pc_q;
  assign pc_plus_step = pc_q + PC_WIDTH'(STEP);

  assign ras_count     = count_q;
  assign ras_empty     = (count_q == '0);
  assign ras_full      = (count_q == CNT_W'(RAS_DEPTH));
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;
`ifdef PC_ALIGN_CHECK_EN
  assign pc_misaligned = mis_q;
`endif

  // Pointer arithmetic wraps naturally because RAS_DEPTH is a power of two.
  assign top_inc = top + 1'b1;
  assign top_dec = top - 1'b1;

  // Next-state decode. Every candidate target (load, relative, pop) is
  // funnelled through `target` so the optional alignment check sits in one
  // place and can cancel the push/pop that would accompany it.
  always_comb begin
    pc_next     = pc_q;
    target      = '0;
    take_target = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    ovf_set     = 1'b0;
    unf_set     = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    mis_set     = 1'b0;
`endif
    if (pc_en) begin
      if (ret) begin
        if (ras_empty) begin
          unf_set = 1'b1;
        end else begin
          target      = ras_mem[top];
          take_target = 1'b1;
          pop         = 1'b1;
        end
      end else begin
        unique case (sel)
          SEL_HOLD: pc_next = pc_q;
          SEL_STEP: pc_next = pc_plus_step;
          SEL_LOAD: begin
            target      = in_addr;
            take_target = 1'b1;
            push        = link;
          end
          SEL_REL: begin
            target      = pc_q + rel_off;
            take_target = 1'b1;
            push        = link;
          end
        endcase
      end

      if (take_target) begin
`ifdef PC_ALIGN_CHECK_EN
        if (target[1:0] != 2'b00) begin
          mis_set = 1'b1;
          push    = 1'b0;
          pop     = 1'b0;
        end else begin
          pc_next = target;
        end
`else
        pc_next = target;
`endif
      end

      ovf_set = push && ras_full;
    end
  end

  // PC, stack pointer, count and sticky flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= RESET_VECTOR;
      top     <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      pc_q  <= pc_next;
      ovf_q <= ovf_q | ovf_set;
      unf_q <= unf_q | unf_set;
`ifdef PC_ALIGN_CHECK_EN
      mis_q <= mis_q | mis_set;
`endif
      if (push) begin
        // When full, advancing the pointer lands on the oldest entry,
        // which the write below overwrites; count saturates.
        top <= top_inc;
        if (!ras_full) begin
          count_q <= count_q + 1'b1;
        end
      end else if (pop) begin
        top     <= top_dec;
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Stack storage carries no reset; its contents are qualified by count_q.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      ras_mem[top_inc] <= pc_plus_step;
    end
  end

endmodule

// File: tb/tb_legv8_pc_unit_ras.sv
module tb_legv8_pc_unit_ras;

  logic        clock = 1'b0;
  logic        reset;
  logic        pc_en;
  logic [1:0]  pc_sel;
  logic [63:0] in_addr;
  logic [63:0] offset;
  logic        link;
  logic        ret;
  logic [63:0] pc;
  logic [63:0] pc_plus_step;
  logic [2:0]  ras_count;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_overflow;
  logic        ras_underflow;
`ifdef PC_ALIGN_CHECK_EN
  logic        pc_misaligned;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  legv8_pc_unit_ras #(
    .PC_WIDTH     (64),
    .RESET_VECTOR (64'd0),
    .STEP         (4),
    .RAS_DEPTH    (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .pc_en         (pc_en),
    .pc_sel        (pc_sel),
    .in_addr       (in_addr),
    .offset        (offset),
    .link          (link),
    .ret           (ret),
    .pc            (pc),
    .pc_plus_step  (pc_plus_step),
    .ras_count     (ras_count),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_overflow  (ras_overflow),
`ifdef PC_ALIGN_CHECK_EN
    .ras_underflow (ras_underflow),
    .pc_misaligned (pc_misaligned)
`else
    .ras_underflow (ras_underflow)
`endif
  );

  always #5 clock = ~clock;

  // Reference model: a queue holds return addresses oldest-first.
  logic [63:0] m_pc;
  logic [63:0] m_ras[$];
  logic        m_ovf;
  logic        m_unf;
  logic        m_mis;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit align_on();
`ifdef PC_ALIGN_CHECK_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_update(input bit rst, input bit en, input logic [1:0] sel,
                              input logic [63:0] addr, input logic [63:0] off,
                              input bit lnk, input bit rt);
    logic [63:0] tgt;
    if (rst) begin
      m_pc = 64'd0;
      m_ras.delete();
      m_ovf = 0; m_unf = 0; m_mis = 0;
    end else if (en) begin
      if (rt) begin
        if (m_ras.size() == 0) m_unf = 1;
        else begin
          tgt = m_ras[$];
          if (align_on() && tgt[1:0] != 2'b00) m_mis = 1;
          else begin
            m_pc = tgt;
            void'(m_ras.pop_back());
          end
        end
      end else if (sel == 2'b01) begin
        m_pc = m_pc + 64'd4;
      end else if (sel[1]) begin
        tgt = (sel == 2'b10) ? addr : m_pc + off * 64'd4;
        if (align_on() && tgt[1:0] != 2'b00) m_mis = 1;
        else begin
          if (lnk) begin
            m_ras.push_back(m_pc + 64'd4);
            if (m_ras.size() > 4) begin
              void'(m_ras.pop_front());
              m_ovf = 1;
            end
          end
          m_pc = tgt;
        end
      end
    end
  endtask

  task automatic cycle(input bit rst, input bit en, input logic [1:0] sel,
                       input logic [63:0] addr, input logic [63:0] off,
                       input bit lnk, input bit rt);
    reset = rst; pc_en = en; pc_sel = sel; in_addr = addr;
    offset = off; link = lnk; ret = rt;
    @(posedge clock);
    model_update(rst, en, sel, addr, off, lnk, rt);
    #1;
    check("pc", pc, m_pc);
    check("pc_plus_step", pc_plus_step, m_pc + 64'd4);
    check("ras_count", 64'(ras_count), 64'(m_ras.size()));
    check("ras_empty", 64'(ras_empty), 64'(m_ras.size() == 0));
    check("ras_full", 64'(ras_full), 64'(m_ras.size() == 4));
    check("ras_overflow", 64'(ras_overflow), 64'(m_ovf));
    check("ras_underflow", 64'(ras_underflow), 64'(m_unf));
`ifdef PC_ALIGN_CHECK_EN
    check("pc_misaligned", 64'(pc_misaligned), 64'(m_mis));
`endif
  endtask

  initial begin
    logic [63:0] r_addr;
    logic [63:0] r_off;
    int          r_int;
    m_pc = '0; m_ovf = 0; m_unf = 0; m_mis = 0;

    // Reset, then three sequential steps.
    cycle(1, 0, 2'b00, 0, 0, 0, 0);
    check("rst_pc", pc, 64'd0);
    repeat (3) cycle(0, 1, 2'b01, 0, 0, 0, 0);
    check("seq_pc", pc, 64'd12);
    check("seq_pps", pc_plus_step, 64'd16);

    // Linked call and return.
    cycle(0, 1, 2'b10, 64'h6000_0018, 0, 1, 0);
    check("call_pc", pc, 64'h6000_0018);
    cycle(0, 1, 2'b00, 0, 0, 0, 1);
    check("ret_pc", pc, 64'd16);

    // Relative branch backwards and wrap-around.
    cycle(0, 1, 2'b10, 64'h100, 0, 0, 0);
    cycle(0, 1, 2'b11, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
    check("rel_pc", pc, 64'hF0);
    cycle(0, 1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0);
    cycle(0, 1, 2'b01, 0, 0, 0, 0);
    check("wrap_pc", pc, 64'd0);

    // Five linked calls overflow a depth-4 stack; rets come back newest first.
    for (int k = 1; k <= 5; k++) cycle(0, 1, 2'b10, 64'(k) * 64'h1000, 0, 1, 0);
    check("ovf_flag", 64'(ras_overflow), 64'd1);
    for (int k = 4; k >= 1; k--) begin
      cycle(0, 1, 2'b00, 0, 0, 0, 1);
      check("ret_order", pc, 64'(k) * 64'h1000 + 64'd4);
    end
    cycle(0, 1, 2'b00, 0, 0, 0, 1);
    check("unf_hold_pc", pc, 64'h1004);

    // Disabled cycle changes nothing; ret beats pc_sel=10.
    cycle(0, 1, 2'b10, 64'h2000, 0, 1, 0);
    cycle(0, 0, 2'b01, 64'h3000, 0, 1, 1);
    cycle(0, 1, 2'b10, 64'h9990, 0, 0, 1);
    check("pop_wins", pc, 64'h2004 - 64'h2000 + 64'h1004);

    // Mid-sequence reset with entries and flags set.
    cycle(0, 1, 2'b10, 64'h4000, 0, 1, 0);
    cycle(0, 1, 2'b10, 64'h5000, 0, 1, 0);
    cycle(1, 1, 2'b10, 64'h7000, 0, 1, 0);
    check("midrst_cnt", 64'(ras_count), 64'd0);

`ifdef PC_ALIGN_CHECK_EN
    cycle(0, 1, 2'b10, 64'h6, 0, 1, 0);
    check("misalign_pc", pc, 64'd0);
`endif

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r_addr = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) != 0) r_addr[1:0] = 2'b00;
      r_int = int'($urandom_range(0, 128)) - 64;
      r_off = 64'(longint'(r_int));
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 7) != 0,
            2'($urandom_range(0, 3)), r_addr, r_off,
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
